bulk_out_ctrl: RTL and testbench

Transaction sequencer for the USB bulk OUT endpoint. It sits between the packet decoder and `bulk_ep_out` and answers each OUT or PING token with ACK, NAK, NYET, STALL or silence. It stages every data packet in a one-packet buffer and checks CRC, length and the DATA0/DATA1 toggle. Only good, non-duplicate packets are replayed into `bulk_ep_out` as one AXI-S frame.

---
 rtl/usb_bulk_pkg.sv | 21 ++
 rtl/pkt_buf.sv | 31 +++
 rtl/bulk_out_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_bulk_out_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_bulk_pkg.sv
// Shared definitions for the USB bulk OUT endpoint: PID codes and the
// transaction sequencer state encoding.
package usb_bulk_pkg;

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_NYET  = 4'b0110;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RECV   = 3'd1,
        ST_DROP   = 3'd2,
        ST_HSK    = 3'd3,
        ST_REPLAY = 3'd4,
        ST_REARM  = 3'd5
    } state_t;

endpackage

// File: rtl/pkt_buf.sv
// One-packet staging buffer: simple dual-port RAM, 2^ABITS x 8, with a
// registered read port. The read register holds its value while re is low,
// which the replay path relies on to park a byte under back-pressure.
module pkt_buf #(
    parameter int ABITS = 9
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ABITS-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic             re,
    input  logic [ABITS-1:0] raddr,
    output logic [7:0]       rdata
);

    logic [7:0] mem [0:(1<<ABITS)-1];
    logic [7:0] rdata_q;

    // Write port and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bulk_out_ctrl.sv
// Bulk OUT transaction sequencer: answers OUT/PING tokens with a handshake,
// stages each data packet, and replays good non-duplicate packets as one
// AXI-S frame before re-arming bulk_ep_out.
module bulk_out_ctrl
    import usb_bulk_pkg::*;
#(
    parameter int MAX_PKT    = 512,
    parameter int ABITS      = 9,
    parameter int TIMEOUT    = 1024,
    parameter bit HIGH_SPEED = 1'b1
) (
    input  logic       bulk_ep_out_clock,
    input  logic       reset_n,
    input  logic       ep_halt_i,
    input  logic       ep_clr_toggle_i,
    input  logic       tok_out_i,
    input  logic       tok_ping_i,
    input  logic       rx_tvalid_i,
    output logic       rx_tready_o,
    input  logic [7:0] rx_tdata_i,
    input  logic       rx_end_i,
    input  logic [3:0] rx_pid_i,
    input  logic       rx_crc_err_i,
    output logic       hsk_valid_o,
    input  logic       hsk_ready_i,
    output logic [3:0] hsk_pid_o,
    input  logic       bulk_ep_out_ready_read_i,
    output logic       bulk_ep_out_xfer_o,
    output logic       m_tvalid_o,
    input  logic       m_tready_i,
    output logic       m_tlast_o,
    output logic [7:0] m_tdata_o,
    output logic       toggle_o,
    output logic       busy_o
);

    localparam int CW = ABITS + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t         state_q, state_d;
    logic           toggle_q, toggle_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           pend_q, pend_d;          // good packet awaiting replay
    logic           drop_stall_q, drop_stall_d;
    logic           tok_pend_q, tok_pend_d;  // OUT token seen while replaying
    logic           hsk_valid_q, hsk_valid_d;
    logic [3:0]     hsk_pid_q, hsk_pid_d;
    logic [CW-1:0]  rd_ptr_q, rd_ptr_d;
    logic           rv_q, rv_d;              // RAM read register holds a byte
    logic           rlast_q, rlast_d;        // ... and it is the final byte
    logic           m_tvalid_q, m_tvalid_d;
    logic           m_tlast_q, m_tlast_d;
    logic [7:0]     m_tdata_q, m_tdata_d;
    logic           xfer_q, xfer_d;

    logic             buf_we, buf_re;
    logic [ABITS-1:0] buf_waddr, buf_raddr;
    logic [7:0]       buf_wdata, buf_rdata;
    logic             flip, out_free, tok_live, data_pid;

    pkt_buf #(.ABITS(ABITS)) u_buf (
        .clk   (bulk_ep_out_clock),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (buf_wdata),
        .re    (buf_re),
        .raddr (buf_raddr),
        .rdata (buf_rdata)
    );

    // Next-state, buffer control and output computation.
    always_comb begin
        state_d      = state_q;
        toggle_d     = toggle_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        tmo_d        = tmo_q;
        pend_d       = pend_q;
        drop_stall_d = drop_stall_q;
        tok_pend_d   = tok_pend_q;
        hsk_valid_d  = hsk_valid_q;
        hsk_pid_d    = hsk_pid_q;
        rd_ptr_d     = rd_ptr_q;
        rv_d         = rv_q;
        rlast_d      = rlast_q;
        m_tvalid_d   = m_tvalid_q;
        m_tlast_d    = m_tlast_q;
        m_tdata_d    = m_tdata_q;
        xfer_d       = 1'b0;
        buf_we       = 1'b0;
        buf_waddr    = count_q[ABITS-1:0];
        buf_wdata    = rx_tdata_i;
        buf_re       = 1'b0;
        buf_raddr    = rd_ptr_q[ABITS-1:0];
        flip         = 1'b0;
        out_free     = !m_tvalid_q || m_tready_i;
        tok_live     = tok_pend_q && !rx_end_i;
        data_pid     = (rx_pid_i == PID_DATA0) || (rx_pid_i == PID_DATA1);

        // A token during replay is answered later only if its packet is still
        // in flight when replay finishes; once its end passes it is forgotten.
        if (state_q == ST_REPLAY || state_q == ST_REARM) begin
            if (tok_out_i) begin
                tok_pend_d = 1'b1;
            end else if (rx_end_i) begin
                tok_pend_d = 1'b0;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (tok_out_i) begin
                    count_d = '0;
                    ovf_d   = 1'b0;
                    tmo_d   = '0;
                    pend_d  = 1'b0;
                    if (ep_halt_i) begin
                        drop_stall_d = 1'b1;
                        state_d      = ST_DROP;
                    end else begin
                        state_d = ST_RECV;
                    end
                end else if (tok_ping_i && HIGH_SPEED) begin
                    pend_d      = 1'b0;
                    hsk_valid_d = 1'b1;
                    state_d     = ST_HSK;
                    if (ep_halt_i) begin
                        hsk_pid_d = PID_STALL;
                    end else if (bulk_ep_out_ready_read_i) begin
                        hsk_pid_d = PID_ACK;
                    end else begin
                        hsk_pid_d = PID_NAK;
                    end
                end
            end

            ST_RECV: begin
                tmo_d = tmo_q + TW'(1);
                if (rx_tvalid_i) begin
                    if (count_q == CW'(MAX_PKT)) begin
                        ovf_d = 1'b1;
                    end else begin
                        buf_we  = 1'b1;
                        count_d = count_q + CW'(1);
                    end
                end
                if (rx_end_i) begin
                    if (rx_crc_err_i || ovf_q || !data_pid) begin
                        state_d = ST_IDLE;
                    end else if (rx_pid_i[3] != toggle_q) begin
                        // Duplicate: host missed our last ACK, so ACK again.
                        hsk_valid_d = 1'b1;
                        hsk_pid_d   = PID_ACK;
                        pend_d      = 1'b0;
                        state_d     = ST_HSK;
                    end else begin
                        flip        = 1'b1;
                        hsk_valid_d = 1'b1;
                        hsk_pid_d   = (HIGH_SPEED && !bulk_ep_out_ready_read_i)
                                      ? PID_NYET : PID_ACK;
                        pend_d      = 1'b1;
                        state_d     = ST_HSK;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                end
            end

            ST_DROP: begin
                tmo_d = tmo_q + TW'(1);
                if (rx_end_i) begin
                    if (rx_crc_err_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        hsk_valid_d = 1'b1;
                        hsk_pid_d   = drop_stall_q ? PID_STALL : PID_NAK;
                        pend_d      = 1'b0;
                        state_d     = ST_HSK;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                end
            end

            ST_HSK: begin
                if (hsk_ready_i) begin
                    hsk_valid_d = 1'b0;
                    rd_ptr_d    = '0;
                    rv_d        = 1'b0;
                    rlast_d     = 1'b0;
                    if (!pend_q) begin
                        state_d = ST_IDLE;
                    end else if (count_q == '0) begin
                        state_d = ST_REARM;
                    end else begin
                        state_d = ST_REPLAY;
                    end
                end
            end

            ST_REPLAY: begin
                // Two-stage pipe: RAM read register feeds the output register.
                if (m_tvalid_q && m_tready_i) begin
                    m_tvalid_d = 1'b0;
                end
                if (rv_q && out_free) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = buf_rdata;
                    m_tlast_d  = rlast_q;
                end
                if ((rd_ptr_q < count_q) && (!rv_q || out_free)) begin
                    buf_re   = 1'b1;
                    rd_ptr_d = rd_ptr_q + CW'(1);
                    rlast_d  = (rd_ptr_q == count_q - CW'(1));
                end
                if (buf_re) begin
                    rv_d = 1'b1;
                end else if (out_free) begin
                    rv_d = 1'b0;
                end
                if (m_tvalid_q && m_tready_i && m_tlast_q) begin
                    m_tvalid_d = 1'b0;
                    m_tlast_d  = 1'b0;
                    state_d    = ST_REARM;
                end
            end

            ST_REARM: begin
                if (m_tready_i) begin
                    xfer_d     = 1'b1;
                    tok_pend_d = 1'b0;
                    if (tok_live) begin
                        drop_stall_d = 1'b0;
                        tmo_d        = '0;
                        state_d      = ST_DROP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Clearing the toggle overrides a flip in the same cycle.
        if (ep_clr_toggle_i) begin
            toggle_d = 1'b0;
        end else if (flip) begin
            toggle_d = !toggle_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge bulk_ep_out_clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            toggle_q     <= 1'b0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            tmo_q        <= '0;
            pend_q       <= 1'b0;
            drop_stall_q <= 1'b0;
            tok_pend_q   <= 1'b0;
            hsk_valid_q  <= 1'b0;
            hsk_pid_q    <= '0;
            rd_ptr_q     <= '0;
            rv_q         <= 1'b0;
            rlast_q      <= 1'b0;
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
            m_tdata_q    <= '0;
            xfer_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            toggle_q     <= toggle_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            tmo_q        <= tmo_d;
            pend_q       <= pend_d;
            drop_stall_q <= drop_stall_d;
            tok_pend_q   <= tok_pend_d;
            hsk_valid_q  <= hsk_valid_d;
            hsk_pid_q    <= hsk_pid_d;
            rd_ptr_q     <= rd_ptr_d;
            rv_q         <= rv_d;
            rlast_q      <= rlast_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tlast_q    <= m_tlast_d;
            m_tdata_q    <= m_tdata_d;
            xfer_q       <= xfer_d;
        end
    end

    assign rx_tready_o        = 1'b1;
    assign hsk_valid_o        = hsk_valid_q;
    assign hsk_pid_o          = hsk_pid_q;
    assign m_tvalid_o         = m_tvalid_q;
    assign m_tlast_o          = m_tlast_q;
    assign m_tdata_o          = m_tdata_q;
    assign bulk_ep_out_xfer_o = xfer_q;
    assign toggle_o           = toggle_q;
    assign busy_o             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bulk_out_ctrl.sv
// Scoreboard bench for bulk_out_ctrl: expected handshakes and frame bytes are
// queued as packets are driven and consumed by a monitor on the DUT outputs.
module tb_bulk_out_ctrl;
    import usb_bulk_pkg::*;

    localparam int MAX_PKT = 512;
    localparam int ABITS   = 9;
    localparam int TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       reset_n, ep_halt_i, ep_clr_toggle_i, tok_out_i, tok_ping_i;
    logic       rx_tvalid_i, rx_end_i, rx_crc_err_i, hsk_ready_i;
    logic       ready_read, m_tready_i;
    logic [7:0] rx_tdata_i;
    logic [3:0] rx_pid_i;
    logic       rx_tready_o, hsk_valid_o, xfer_o, m_tvalid_o, m_tlast_o;
    logic       toggle_o, busy_o;
    logic [3:0] hsk_pid_o;
    logic [7:0] m_tdata_o;

    int checks = 0, failures = 0;
    int exp_xfer = 0, act_xfer = 0, cyc = 0, hcyc = 0;
    logic [3:0] exp_hsk[$];
    logic [8:0] exp_byte[$];
    bit tog_m = 1'b0, tready_low = 1'b0;
    bit stall_prev = 1'b0, await_first = 1'b0, pid_seen = 1'b0;
    logic [8:0] prev_ld, e_byte;
    logic [3:0] pid_first;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bulk_out_ctrl #(.MAX_PKT(MAX_PKT), .ABITS(ABITS), .TIMEOUT(TIMEOUT), .HIGH_SPEED(1'b1)) dut (
        .bulk_ep_out_clock        (clk),
        .reset_n                  (reset_n),
        .ep_halt_i                (ep_halt_i),
        .ep_clr_toggle_i          (ep_clr_toggle_i),
        .tok_out_i                (tok_out_i),
        .tok_ping_i               (tok_ping_i),
        .rx_tvalid_i              (rx_tvalid_i),
        .rx_tready_o              (rx_tready_o),
        .rx_tdata_i               (rx_tdata_i),
        .rx_end_i                 (rx_end_i),
        .rx_pid_i                 (rx_pid_i),
        .rx_crc_err_i             (rx_crc_err_i),
        .hsk_valid_o              (hsk_valid_o),
        .hsk_ready_i              (hsk_ready_i),
        .hsk_pid_o                (hsk_pid_o),
        .bulk_ep_out_ready_read_i (ready_read),
        .bulk_ep_out_xfer_o       (xfer_o),
        .m_tvalid_o               (m_tvalid_o),
        .m_tready_i               (m_tready_i),
        .m_tlast_o                (m_tlast_o),
        .m_tdata_o                (m_tdata_o),
        .toggle_o                 (toggle_o),
        .busy_o                   (busy_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Handshake sink (two-cycle latency) and replay sink (random throttle).
    initial begin
        int hw;
        hw = 0;
        hsk_ready_i = 1'b0;
        m_tready_i  = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (hsk_valid_o) hw++; else hw = 0;
            hsk_ready_i = (hw >= 2);
            m_tready_i  = tready_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Output monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (stall_prev)
                check_eq("m_hold", {23'd0, m_tvalid_o, m_tlast_o, m_tdata_o}, {23'd0, 1'b1, prev_ld});
            stall_prev = m_tvalid_o && !m_tready_i;
            prev_ld    = {m_tlast_o, m_tdata_o};
            if (m_tvalid_o && await_first) begin
                check_eq("first_lat", cyc - hcyc, 3);
                await_first = 1'b0;
            end
            if (m_tvalid_o && m_tready_i) begin
                if (exp_byte.size() == 0) begin
                    check_eq("byte_unexp", {23'd0, m_tlast_o, m_tdata_o}, 32'hFFFF_FFFF);
                end else begin
                    e_byte = exp_byte.pop_front();
                    check_eq("byte", {23'd0, m_tlast_o, m_tdata_o}, {23'd0, e_byte});
                end
            end
            if (hsk_valid_o) begin
                if (!pid_seen) begin
                    pid_first = hsk_pid_o;
                    pid_seen  = 1'b1;
                end
                if (hsk_ready_i) begin
                    check_eq("hsk_stable", hsk_pid_o, pid_first);
                    if (exp_hsk.size() == 0) check_eq("hsk_unexp", hsk_pid_o, 32'hFFFF_FFFF);
                    else check_eq("hsk_pid", hsk_pid_o, exp_hsk.pop_front());
                    pid_seen    = 1'b0;
                    await_first = (exp_byte.size() != 0);
                    hcyc        = cyc;
                end
            end
            if (xfer_o) act_xfer++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_tok_out();
        tok_out_i = 1'b1; tick(); tok_out_i = 1'b0;
    endtask

    task automatic send_bytes(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            rx_tvalid_i = 1'b1;
            rx_tdata_i  = 8'(base + i);
            tick();
        end
        rx_tvalid_i = 1'b0;
    endtask

    task automatic end_pkt(input logic [3:0] pid, input bit crc, input bit hsk_exp);
        rx_end_i = 1'b1; rx_pid_i = pid; rx_crc_err_i = crc;
        tick();
        rx_end_i = 1'b0; rx_crc_err_i = 1'b0;
        check_eq("hsk_lat", hsk_valid_o, hsk_exp);
    endtask

    // Reference behaviour of one OUT transaction; queues what should follow.
    task automatic out_pkt(input logic [3:0] pid, input int n, input int base, input bit crc);
        bit has_h, frame, tg;
        logic [3:0] h;
        has_h = 1'b0; frame = 1'b0; h = PID_ACK;
        tg = (pid == PID_DATA1);
        if (ep_halt_i) begin
            has_h = !crc; h = PID_STALL;
        end else if (crc || n > MAX_PKT || !(pid == PID_DATA0 || pid == PID_DATA1)) begin
            has_h = 1'b0;
        end else if (tg != tog_m) begin
            has_h = 1'b1; h = PID_ACK;
        end else begin
            has_h = 1'b1; frame = 1'b1;
            h = ready_read ? PID_ACK : PID_NYET;
            tog_m = !tog_m;
            exp_xfer++;
        end
        if (has_h) exp_hsk.push_back(h);
        if (frame)
            for (int i = 0; i < n; i++) exp_byte.push_back({i == n - 1, 8'(base + i)});
        pulse_tok_out();
        tick();
        send_bytes(n, base);
        end_pkt(pid, crc, has_h);
    endtask

    task automatic ping();
        logic [3:0] h;
        h = ep_halt_i ? PID_STALL : (ready_read ? PID_ACK : PID_NAK);
        exp_hsk.push_back(h);
        tok_ping_i = 1'b1; tick(); tok_ping_i = 1'b0;
        check_eq("ping_lat", hsk_valid_o, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy_o || exp_hsk.size() != 0 || exp_byte.size() != 0) && n < 5000) begin
            tick(); n++;
        end
        check_eq({tag, "_idle"}, busy_o, 0);
        repeat (3) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0; ep_halt_i = 1'b0; ep_clr_toggle_i = 1'b0;
        tok_out_i = 1'b0; tok_ping_i = 1'b0; rx_tvalid_i = 1'b0; rx_tdata_i = '0;
        rx_end_i = 1'b0; rx_pid_i = '0; rx_crc_err_i = 1'b0; ready_read = 1'b1;
        repeat (4) tick();
        check_eq("rst_hsk_valid", hsk_valid_o, 0);
        check_eq("rst_hsk_pid", hsk_pid_o, 0);
        check_eq("rst_m_tvalid", m_tvalid_o, 0);
        check_eq("rst_m_tlast", m_tlast_o, 0);
        check_eq("rst_m_tdata", m_tdata_o, 0);
        check_eq("rst_xfer", xfer_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_tready", rx_tready_o, 1);
        check_eq("rst_toggle", toggle_o, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Good DATA0, 64 bytes 0x00..0x3F
        out_pkt(PID_DATA0, 64, 8'h00, 1'b0);
        wait_idle("t1");
        check_eq("t1_toggle", toggle_o, tog_m);
        check_eq("t1_xfer", act_xfer, exp_xfer);

        // Same DATA0 again: duplicate
        out_pkt(PID_DATA0, 64, 8'h00, 1'b0);
        wait_idle("t2");
        check_eq("t2_toggle", toggle_o, tog_m);

        // CRC error on a full packet, then an oversize packet
        out_pkt(PID_DATA1, 512, 8'h10, 1'b1);
        wait_idle("t3a");
        out_pkt(PID_DATA1, 513, 8'h20, 1'b0);
        wait_idle("t3b");
        check_eq("t3_toggle", toggle_o, tog_m);

        // Halted endpoint and PINGs
        ep_halt_i = 1'b1;
        out_pkt(PID_DATA1, 8, 8'hA0, 1'b0);
        wait_idle("t4a");
        ping();
        wait_idle("t4b");
        ep_halt_i = 1'b0;
        ready_read = 1'b0;
        ping();
        wait_idle("t4c");
        ready_read = 1'b1;
        ping();
        wait_idle("t4d");

        // bulk_ep_out not ready: NYET, frame still replayed
        ready_read = 1'b0;
        out_pkt(PID_DATA1, 32, 8'h40, 1'b0);
        wait_idle("t5");
        ready_read = 1'b1;
        check_eq("t5_toggle", toggle_o, tog_m);

        // Back-pressured replay with a second OUT arriving mid-replay
        tready_low = 1'b1;
        out_pkt(PID_DATA0, 16, 8'h80, 1'b0);
        n = 0;
        while (!m_tvalid_o && n < 100) begin tick(); n++; end
        check_eq("bp_start", m_tvalid_o, 1);
        pulse_tok_out();
        send_bytes(4, 8'hC0);
        repeat (5) tick();
        tready_low = 1'b0;
        n = 0;
        while (act_xfer < exp_xfer && n < 500) begin tick(); n++; end
        check_eq("bp_xfer", act_xfer, exp_xfer);
        repeat (2) tick();
        exp_hsk.push_back(PID_NAK);
        send_bytes(4, 8'hC4);
        end_pkt(PID_DATA1, 1'b0, 1'b1);
        wait_idle("t6");
        check_eq("t6_toggle", toggle_o, tog_m);

        // Zero-length DATA1
        out_pkt(PID_DATA1, 0, 0, 1'b0);
        wait_idle("t7");
        check_eq("t7_toggle", toggle_o, tog_m);
        check_eq("t7_xfer", act_xfer, exp_xfer);

        // Toggle clear after a good packet
        out_pkt(PID_DATA0, 4, 8'h55, 1'b0);
        wait_idle("t8");
        ep_clr_toggle_i = 1'b1; tick(); ep_clr_toggle_i = 1'b0;
        tog_m = 1'b0;
        check_eq("t8_clr", toggle_o, tog_m);

        // Packet that never ends
        pulse_tok_out();
        send_bytes(3, 8'h11);
        repeat (TIMEOUT + 8) tick();
        check_eq("t9_busy", busy_o, 0);
        check_eq("t9_toggle", toggle_o, tog_m);

        // Reset in the middle of a packet
        out_pkt(PID_DATA0, 4, 8'h66, 1'b0);
        wait_idle("t10a");
        pulse_tok_out();
        send_bytes(5, 8'h77);
        reset_n = 1'b0; repeat (2) tick(); reset_n = 1'b1;
        tog_m = 1'b0;
        tick();
        check_eq("t10_toggle", toggle_o, 0);
        check_eq("t10_busy", busy_o, 0);
        check_eq("t10_m_tvalid", m_tvalid_o, 0);
        out_pkt(PID_DATA0, 8, 8'hE0, 1'b0);
        wait_idle("t10b");
        check_eq("t10_toggle2", toggle_o, tog_m);

        check_eq("end_hsk_q", exp_hsk.size(), 0);
        check_eq("end_byte_q", exp_byte.size(), 0);
        check_eq("end_xfer", act_xfer, exp_xfer);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
